// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 32x32 register file: runs the post-reset clear of r1..r31,
// then shares the port between core writeback and a 1-entry buffered multi-cycle result.
module regfile_wr_arbiter #(
    parameter int MAX_WAIT     = 4,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_req,
    input  logic        core_we,
    input  logic [4:0]  core_addr,
    input  logic [31:0] core_data,
    output logic        core_stall,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        init_done
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    state_t      r_state;
    logic [4:0]  r_clr_cnt;
    logic [3:0]  r_wait_cnt;
    logic        r_buf_full;
    logic [4:0]  r_buf_addr;
    logic [31:0] r_buf_data;
    logic        r_init_done;

    logic w_run;
    logic w_force;
    logic w_core_wr;
    logic w_buf_wr;
    logic w_waw;
    logic w_md_ready;
    logic w_accept;

    // Port selection; a write to r0 never counts as a core grant.
    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_force    = r_buf_full && (r_wait_cnt == LP_MAX_WAIT);
        w_core_wr  = w_run && core_we && (core_addr != 5'd0) && !w_force;
        w_buf_wr   = w_run && r_buf_full && !w_core_wr;
        w_waw      = w_core_wr && r_buf_full && (r_buf_addr == core_addr);
        w_md_ready = !rst && w_run && (!r_buf_full || w_buf_wr);
        w_accept   = md_valid && w_md_ready;
    end

    // Register-file port mux; nothing is written while reset is asserted.
    always_comb begin
        rf_we      = 1'b0;
        rf_addr    = 5'd0;
        rf_data    = 32'd0;
        core_stall = !w_run || w_force;
        md_ready   = w_md_ready;
        init_done  = r_init_done;
        if (rst) begin
            rf_we = 1'b0;
        end else if (!w_run) begin
            rf_we   = 1'b1;
            rf_addr = r_clr_cnt;
            rf_data = 32'd0;
        end else if (w_core_wr) begin
            rf_we   = 1'b1;
            rf_addr = core_addr;
            rf_data = core_data;
        end else if (w_buf_wr) begin
            rf_we   = 1'b1;
            rf_addr = r_buf_addr;
            rf_data = r_buf_data;
        end else begin
            rf_we = 1'b0;
        end
    end

    // Control FSM, clear counter, buffer and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CLR_ON_RESET ? ST_INIT : ST_RUN;
            r_clr_cnt   <= 5'd1;
            r_wait_cnt  <= 4'd0;
            r_buf_full  <= 1'b0;
            r_buf_addr  <= 5'd0;
            r_buf_data  <= 32'd0;
            r_init_done <= !CLR_ON_RESET;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_clr_cnt == 5'd31) begin
                        r_state     <= ST_RUN;
                        r_clr_cnt   <= 5'd1;
                        r_init_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 5'd1;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        r_state     <= ST_INIT;
                        r_clr_cnt   <= 5'd1;
                        r_init_done <= 1'b0;
                        r_buf_full  <= 1'b0;
                        r_wait_cnt  <= 4'd0;
                    end else begin
                        // A new result may be loaded in the same cycle the old one drains.
                        if (w_accept) begin
                            r_buf_full <= (md_addr != 5'd0);
                            r_buf_addr <= md_addr;
                            r_buf_data <= md_data;
                        end else if (w_buf_wr || w_waw) begin
                            r_buf_full <= 1'b0;
                        end else begin
                            r_buf_full <= r_buf_full;
                        end
                        if (w_accept || w_buf_wr || w_waw) begin
                            r_wait_cnt <= 4'd0;
                        end else if (r_buf_full && (r_wait_cnt < LP_MAX_WAIT)) begin
                            r_wait_cnt <= r_wait_cnt + 4'd1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt;
                        end
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with hand-computed expectations (MAX_WAIT=4).
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        core_we;
    logic [4:0]  core_addr;
    logic [31:0] core_data;
    logic        core_stall;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        init_done;

    int total_cnt = 0;
    int bad_cnt   = 0;

    regfile_wr_arbiter #(.MAX_WAIT(4), .CLR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req),
        .core_we(core_we), .core_addr(core_addr), .core_data(core_data),
        .core_stall(core_stall),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        if (obs !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_req   = 1'b0;
        core_we   = 1'b0;
        core_addr = 5'd0;
        core_data = 32'd0;
        md_valid  = 1'b0;
        md_addr   = 5'd0;
        md_data   = 32'd0;
    endtask

    // Checks n clear cycles starting at address first; ends just after the last edge.
    task automatic check_clear(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_val("clr_we",    32'(rf_we),      32'd1);
            chk_val("clr_addr",  32'(rf_addr),    32'(first + i));
            chk_val("clr_data",  rf_data,         32'd0);
            chk_val("clr_stall", 32'(core_stall), 32'd1);
            chk_val("clr_mdrdy", 32'(md_ready),   32'd0);
            chk_val("clr_done",  32'(init_done),  32'd0);
            tick();
        end
    endtask

    task automatic md_push(input logic [4:0] a, input logic [31:0] d);
        md_valid = 1'b1;
        md_addr  = a;
        md_data  = d;
        @(negedge clk);
        chk_val("push_rdy", 32'(md_ready), 32'd1);
        tick();
        md_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk_val("rst_we",   32'(rf_we),     32'd0);
        tick();
        @(negedge clk);
        chk_val("rst_done", 32'(init_done), 32'd0);
        chk_val("rst_we2",  32'(rf_we),     32'd0);
        tick();
        rst = 1'b0;

        check_clear(1, 31);
        @(negedge clk);
        chk_val("post_done",  32'(init_done),  32'd1);
        chk_val("post_stall", 32'(core_stall), 32'd0);
        chk_val("post_we",    32'(rf_we),      32'd0);

        // Buffered md write lands the cycle after acceptance.
        md_push(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk_val("md_we",   32'(rf_we),    32'd1);
        chk_val("md_addr", 32'(rf_addr),  32'd5);
        chk_val("md_data", rf_data,       32'hDEADBEEF);
        chk_val("md_rdy",  32'(md_ready), 32'd1);
        tick();

        // Core holds the port 4 cycles, then a forced drain of r7.
        md_push(5'd7, 32'h0000_0077);
        core_we = 1'b1; core_addr = 5'd3; core_data = 32'h0000_0033;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_val("blk_addr",  32'(rf_addr),    32'd3);
            chk_val("blk_stall", 32'(core_stall), 32'd0);
            chk_val("blk_rdy",   32'(md_ready),   32'd0);
            tick();
        end
        @(negedge clk);
        chk_val("frc_stall", 32'(core_stall), 32'd1);
        chk_val("frc_we",    32'(rf_we),      32'd1);
        chk_val("frc_addr",  32'(rf_addr),    32'd7);
        chk_val("frc_data",  rf_data,         32'h0000_0077);
        chk_val("frc_rdy",   32'(md_ready),   32'd1);
        tick();
        @(negedge clk);
        chk_val("res_stall", 32'(core_stall), 32'd0);
        chk_val("res_addr",  32'(rf_addr),    32'd3);
        chk_val("res_data",  rf_data,         32'h0000_0033);
        tick();
        core_we = 1'b0;

        // WAW: newer core write to r9 drops the buffered 0x1.
        md_push(5'd9, 32'h0000_0001);
        core_we = 1'b1; core_addr = 5'd9; core_data = 32'h0000_0002;
        @(negedge clk);
        chk_val("waw_addr", 32'(rf_addr), 32'd9);
        chk_val("waw_data", rf_data,      32'h0000_0002);
        tick();
        core_we = 1'b0;
        @(negedge clk);
        chk_val("waw_we",  32'(rf_we),    32'd0);
        chk_val("waw_rdy", 32'(md_ready), 32'd1);
        tick();

        // r0: core write to r0 and md to r0 both vanish.
        core_we = 1'b1; core_addr = 5'd0; core_data = 32'h1234_5678;
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk_val("r0_we",  32'(rf_we),    32'd0);
        chk_val("r0_rdy", 32'(md_ready), 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        chk_val("r0_we2",  32'(rf_we),    32'd0);
        chk_val("r0_rdy2", 32'(md_ready), 32'd1);
        tick();

        // Core write to r0 does not block a full buffer.
        md_push(5'd12, 32'h0000_00C0);
        core_we = 1'b1; core_addr = 5'd0; core_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_val("r0buf_we",   32'(rf_we),   32'd1);
        chk_val("r0buf_addr", 32'(rf_addr), 32'd12);
        chk_val("r0buf_data", rf_data,      32'h0000_00C0);
        tick();
        core_we = 1'b0;

        // clr_req with r4 buffered: entry dropped, full clear reruns.
        md_push(5'd4, 32'h0000_0444);
        clr_req = 1'b1; core_we = 1'b1; core_addr = 5'd2; core_data = 32'h0000_0022;
        @(negedge clk);
        chk_val("clr_req_addr", 32'(rf_addr), 32'd2);
        tick();
        idle_inputs();
        check_clear(1, 15);
        clr_req = 1'b1;
        check_clear(16, 1);
        clr_req = 1'b0;
        check_clear(17, 15);
        @(negedge clk);
        chk_val("reclr_done", 32'(init_done), 32'd1);
        chk_val("reclr_we",   32'(rf_we),     32'd0);
        tick();

        // Reset at clear cycle 10 restarts INIT at r1.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check_clear(1, 9);
        rst = 1'b1;
        @(negedge clk);
        chk_val("mid_rst_we", 32'(rf_we), 32'd0);
        tick();
        rst = 1'b0;
        check_clear(1, 31);
        @(negedge clk);
        chk_val("fin_done", 32'(init_done), 32'd1);
        chk_val("fin_we",   32'(rf_we),     32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Owns the single write port of the 32x32 register file. It sequences a post-reset clear of r1..r31 and then shares the port between the single-cycle core writeback path and a multi-cycle unit (mul/div, syscall return). The multi-cycle unit's write is held in a 1-entry buffer until the port is granted. The block sits between the writeback mux, the multi-cycle unit and the register file write port (WE, write_addr, write_data).

Parameters:
MAX_WAIT, 4, consecutive blocked cycles a buffered write tolerates before the core is stalled to drain it (range 1..15)
CLR_ON_RESET, 1, 1 = run the INIT clear sequence after reset; 0 = enter RUN directly

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
clr_req  input  1  pulse in RUN restarts the clear sequence
core_we  input  1  core writeback enable
core_addr  input  5  core writeback register
core_data  input  32  core writeback data
core_stall  output  1  core must hold PC/state; core_we ignored this cycle
md_valid  input  1  multi-cycle unit has a result
md_addr  input  5  destination register
md_data  input  32  result data
md_ready  output  1  buffer can accept; transfer on md_valid&&md_ready at posedge
rf_we  output  1  register file write enable
rf_addr  output  5  register file write address
rf_data  output  32  register file write data
init_done  output  1  high once the clear sequence has completed

Behaviour:
- States: INIT, RUN. Reset -> INIT if CLR_ON_RESET=1, else RUN. Reset clears the buffer, clr_cnt=1 and wait_cnt=0. init_done=0 after reset if CLR_ON_RESET=1, else 1.
- rf_* outputs are combinational from registered state and current inputs. No added latency on the core path: the core write lands at the same posedge as without the arbiter.
- INIT:
  - rf_we=1, rf_addr=clr_cnt, rf_data=0, core_stall=1, md_ready=0.
  - clr_cnt increments each cycle. After the cycle with clr_cnt=31, go to RUN and set init_done=1.
  - INIT lasts exactly 31 cycles.
- RUN port selection, per cycle, in priority order:
  1. Forced drain: buf_full && wait_cnt==MAX_WAIT. core_stall=1 and the buffer writes; core_we is ignored.
  2. core_we=1: core writes and core_stall=0.
  3. buf_full: buffer writes.
  4. Otherwise rf_we=0.
- Buffered write reaches the port no earlier than the cycle after acceptance.
- wait_cnt:
  - Increments each cycle the buffer is full and not written.
  - Clears when the buffer drains.
  - Saturates at MAX_WAIT.
- md_ready = RUN && (!buf_full || buffer writes this cycle). Back-to-back accept and drain is allowed.
- Address 0:
  - rf_we is never 1 with rf_addr=0.
  - A core write to r0 gives rf_we=0 and is not counted as a core grant, so a full buffer may write that cycle.
  - An md transfer to r0 is accepted and discarded; the buffer stays empty.
- WAW: if core writes addr A (A!=0) while the buffer holds A and is not written this cycle, the buffered entry is dropped (the core write is newer).
- clr_req in RUN:
  - Next cycle enters INIT with clr_cnt=1 and init_done=0.
  - Any buffered entry is discarded. wait_cnt=0.
  - clr_req in INIT is ignored.
- Reset mid-INIT or mid-buffer: everything returns to reset values. No write is issued in the reset cycle (rf_we=0 while rst=1).

Test Plan:
- Reset, CLR_ON_RESET=1 -> rf_we=1 with rf_addr=1..31 on 31 consecutive cycles, rf_data=0, core_stall=1 throughout; then init_done=1, core_stall=0.
- RUN, core_we=0, md transfer addr 5 data 0xDEADBEEF at cycle N -> cycle N+1: rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; md_ready=1 at N+1.
- Buffer holds r7; core_we=1 to r3 for 4 cycles, MAX_WAIT=4 -> 5th cycle: core_stall=1 and r7 is written; core write to r3 resumes the cycle after.
- Buffer holds r9 = 0x1; core writes r9 = 0x2 -> rf writes 0x2 and the buffer empties; r9 is never written with 0x1.
- md transfer to r0, and core_we=1 with core_addr=0 -> rf_we stays 0 and md_ready=1 next cycle.
- clr_req with buffer full -> entry discarded, a 31-cycle clear reruns, init_done low during it; rst asserted at clear cycle 10 -> INIT restarts at rf_addr=1.
